// File: rtl/fifo_wr_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : fifo_wr_arbiter_if
// Description : Producer handshake and FIFO write-port bundle for the arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
interface fifo_wr_arbiter_if #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8
);
    localparam int ID_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]            req_ready;
    logic                          fifo_full;
    logic                          fifo_w_en;
    logic [DATA_WIDTH-1:0]         fifo_data_in;
    logic [ID_W-1:0]               grant_id;
    logic                          busy;

    modport master (
        input  req_valid, req_data, fifo_full,
        output req_ready, fifo_w_en, fifo_data_in, grant_id, busy
    );

    modport slave (
        output req_valid, req_data, fifo_full,
        input  req_ready, fifo_w_en, fifo_data_in, grant_id, busy
    );
endinterface
`default_nettype wire

// File: rtl/fifo_wr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : fifo_wr_arbiter
// Description : Round-robin, burst-limited arbiter sharing one FIFO write port.
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_wr_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8,
    parameter int MAX_BURST  = 4
) (
    input  wire logic         clk,
    input  wire logic         rst,
    fifo_wr_arbiter_if.master bus
);
    localparam int ID_W  = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(MAX_BURST + 1);
    localparam logic [NUM_REQ-1:0] c_one_hot0 = NUM_REQ'(1);
    localparam logic [CNT_W-1:0]   c_last_cnt = CNT_W'(MAX_BURST - 1);
    localparam logic [ID_W-1:0]    c_last_id  = ID_W'(NUM_REQ - 1);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t           r_state, w_state_n;
    logic [ID_W-1:0]  r_grant_id, w_grant_id_n;
    logic [ID_W-1:0]  r_rr_ptr, w_rr_ptr_n;
    logic [CNT_W-1:0] r_burst_cnt, w_burst_cnt_n;

    logic             w_found;
    logic [ID_W-1:0]  w_winner;
    logic [ID_W-1:0]  w_winner_next;
    logic             w_owner_valid;
    logic             w_xfer;
    logic             w_release;

    // Round-robin search: first requester at or after r_rr_ptr, wrapping.
    always_comb begin
        int idx;
        w_found  = 1'b0;
        w_winner = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = int'(r_rr_ptr) + k;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (!w_found && bus.req_valid[idx]) begin
                w_found  = 1'b1;
                w_winner = ID_W'(idx);
            end
        end
    end

    assign w_winner_next = (w_winner == c_last_id) ? '0 : w_winner + ID_W'(1);

    assign w_owner_valid = bus.req_valid[r_grant_id];
    assign w_xfer        = (r_state == GRANT) && w_owner_valid && !bus.fifo_full;
    // A stalled owner keeps its grant; only a dropped valid or a finished burst releases it.
    assign w_release     = (r_state == GRANT) &&
                           (!w_owner_valid || (w_xfer && (r_burst_cnt == c_last_cnt)));

    assign bus.req_ready    = w_xfer ? (c_one_hot0 << r_grant_id) : '0;
    assign bus.fifo_w_en    = w_xfer;
    assign bus.fifo_data_in = bus.req_data[r_grant_id*DATA_WIDTH +: DATA_WIDTH];
    assign bus.grant_id     = r_grant_id;
    assign bus.busy         = (r_state == GRANT);

    always_comb begin
        w_state_n     = r_state;
        w_grant_id_n  = r_grant_id;
        w_rr_ptr_n    = r_rr_ptr;
        w_burst_cnt_n = r_burst_cnt;
        case (r_state)
            IDLE: begin
                if (w_found) begin
                    w_state_n     = GRANT;
                    w_grant_id_n  = w_winner;
                    w_rr_ptr_n    = w_winner_next;
                    w_burst_cnt_n = '0;
                end
            end
            GRANT: begin
                if (w_release) begin
                    w_burst_cnt_n = '0;
                    if (w_found) begin
                        w_grant_id_n = w_winner;
                        w_rr_ptr_n   = w_winner_next;
                    end else begin
                        w_state_n = IDLE;
                    end
                end else if (w_xfer) begin
                    w_burst_cnt_n = r_burst_cnt + CNT_W'(1);
                end
            end
            default: begin
                w_state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= IDLE;
            r_grant_id  <= '0;
            r_rr_ptr    <= '0;
            r_burst_cnt <= '0;
        end else begin
            r_state     <= w_state_n;
            r_grant_id  <= w_grant_id_n;
            r_rr_ptr    <= w_rr_ptr_n;
            r_burst_cnt <= w_burst_cnt_n;
        end
    end
endmodule
`default_nettype wire

// File: doc/fifo_wr_arbiter.md
# fifo_wr_arbiter

Round-robin write arbiter that shares one synchronous FIFO write port among NUM_REQ producers. Each producer offers words over a valid/ready handshake. The arbiter grants one producer at a time for bursts of up to MAX_BURST words and drives the FIFO's write enable and data input. It respects the FIFO's full flag, so no word is ever dropped or duplicated.

## Interface
- NUM_REQ, 4: number of producers, at least 2.
- DATA_WIDTH, 8: word width, matches the FIFO data_width.
- MAX_BURST, 4: maximum words transferred per grant, at least 1.

- clk  input  1  single clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- req_valid  input  NUM_REQ  bit i: producer i offers a word.
- req_data  input  NUM_REQ*DATA_WIDTH  producer i word at bits [i*DATA_WIDTH +: DATA_WIDTH].
- req_ready  output  NUM_REQ  bit i: word from producer i is accepted this cycle.
- fifo_full  input  1  full flag from the FIFO.
- fifo_w_en  output  1  FIFO write enable.
- fifo_data_in  output  DATA_WIDTH  FIFO write data.
- grant_id  output  $clog2(NUM_REQ)  current owner index (registered).
- busy  output  1  high while in GRANT.

## Operation
- State machine with two states:
  - IDLE: no owner.
  - GRANT: owner = grant_id.
- Registers:
  - state
  - grant_id
  - rr_ptr: highest-priority index for the next arbitration
  - burst_cnt: width $clog2(MAX_BURST+1)
- Arbitration is a round-robin search over req_valid, starting at rr_ptr and wrapping modulo NUM_REQ. The first set bit wins.
- IDLE:
  - If any req_valid is set, go to GRANT.
  - grant_id = winner, burst_cnt = 0, rr_ptr = winner+1 mod NUM_REQ.
  - Otherwise stay in IDLE.
- GRANT is combinational from registered state:
  - xfer = req_valid[grant_id] & !fifo_full.
  - req_ready[grant_id] = xfer; all other ready bits are 0.
  - fifo_w_en = xfer.
  - fifo_data_in = req_data slice of grant_id. It is driven with the owner's slice even when xfer = 0.
- Burst counting: on xfer, burst_cnt increments.
- Release occurs when either holds:
  - req_valid[grant_id] = 0, or
  - xfer with burst_cnt = MAX_BURST-1.
- On release, arbitrate in the same cycle over the current req_valid, starting at rr_ptr:
  - A winner exists: stay in GRANT with the new grant_id, burst_cnt = 0, rr_ptr = winner+1. The old owner wins only if it is the sole requester.
  - No winner: go to IDLE.
- fifo_full in GRANT stalls the transfer:
  - No xfer, and burst_cnt holds.
  - No release due to full; the owner keeps the grant.
- Producer obligation: once req_valid is high, req_data stays stable until the corresponding ready is seen. Dropping valid before ready forfeits the grant.
- Outside GRANT, all req_ready bits are 0 and fifo_w_en is 0.

## Timing
- Reset (rst low, asynchronous) forces, immediately:
  - state = IDLE, grant_id = 0, rr_ptr = 0, burst_cnt = 0.
  - All req_ready bits, fifo_w_en and busy are 0.
  - fifo_data_in = slice 0.
- Reset mid-burst aborts the burst. No write is issued in any cycle while rst is low.
- Latency from IDLE: req_valid rises in cycle n → grant registered at the end of n → first write in cycle n+1 if not full.
- Back-to-back: in GRANT, one word per cycle while valid and not full.
- Handover: the last word of the old owner in cycle m is followed by the first word of the new owner in cycle m+1. There are no bubbles between owners.
- Release on valid low costs one idle cycle: the owner-valid-low cycle.
- A word is transferred exactly once, on a rising edge where req_ready[i] & req_valid[i] = 1.
- fifo_full is sampled combinationally. The FIFO full flag must be valid in the same cycle.

## Test plan
- Reset: hold rst low with all req_valid = 1 → fifo_w_en = 0, req_ready = 0, grant_id = 0, busy = 0. Release rst → owner is 0 at the next edge.
- Fairness: NUM_REQ = 4, MAX_BURST = 4, all four producers continuously valid, FIFO never full:
  - Expected owner sequence: 0,0,0,0,1,1,1,1,2,…,3, then 0 again.
  - 16 writes in 16 consecutive cycles after the first grant.
- Single requester: only producer 2 is valid with 10 words → 10 consecutive writes. Grant is re-issued to 2 after every 4 words with no bubble; data order is preserved.
- Full stall: owner 1 mid-burst with burst_cnt = 2, fifo_full high for 3 cycles:
  - No w_en and no ready during those cycles; burst_cnt stays 2 and the owner is held.
  - After full clears, exactly 2 more words are written before handover.
- Early release: owner 3 drops valid after 1 word while producers 0 and 1 are valid → the next owner is 0, since rr_ptr wrapped from 3 to 0.
- Async reset mid-burst: assert rst between edges during a write cycle → fifo_w_en falls immediately. After reset the FIFO write count equals the number of completed handshakes.
